// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator decode path and its downstream consumers.
package cmp_pkg;

  localparam int CMP_WINDOW_LOG2_DEFAULT = 8;
  localparam int CMP_SYNC_STAGES_DEFAULT = 2;

  typedef logic [CMP_WINDOW_LOG2_DEFAULT:0] cmp_result_t;

endpackage

// File: rtl/cmp_sync.sv
// Flop-chain synchronizer for asynchronous analog outputs; chain clears to 0 on reset.
module cmp_sync
  import cmp_pkg::*;
#(
  parameter int STAGES = CMP_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Next value: shift the raw input in at the low end.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {STAGES{1'b0}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/cmp_decode.sv
// Comparator receive path: synchronize, chopper-demodulate, accumulate a power-of-two
// window of decisions and present the ones-count on a valid/ready slot.
module cmp_decode
  import cmp_pkg::*;
#(
  parameter int WINDOW_LOG2 = CMP_WINDOW_LOG2_DEFAULT,
  parameter int SYNC_STAGES = CMP_SYNC_STAGES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   cmp_out,
  input  logic                   cmp_p2,
  input  logic                   sample,
  output logic                   decision,
  output logic                   decision_valid,
  output logic [WINDOW_LOG2:0]   result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);

  logic                   cmp_sync_s;
  logic                   sample_q;
  logic                   decision_q, decision_d;
  logic                   decision_valid_q, decision_valid_d;
  logic [WINDOW_LOG2:0]   acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [WINDOW_LOG2:0]   result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   strobe_s;
  logic                   dec_bit_s;
  logic [WINDOW_LOG2:0]   sum_s;
  logic                   last_s;
  logic                   handshake_s;

  cmp_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cmp_out),
    .q_o   (cmp_sync_s)
  );

  // Decision, accumulator and output-slot next-state logic.
  always_comb begin
    strobe_s         = sample & ~sample_q & en;
    dec_bit_s        = cmp_sync_s ^ cmp_p2;
    sum_s            = acc_q + {{WINDOW_LOG2{1'b0}}, dec_bit_s};
    last_s           = (wcnt_q == {WINDOW_LOG2{1'b1}});
    handshake_s      = result_valid_q & result_ready;

    decision_d       = decision_q;
    decision_valid_d = 1'b0;
    acc_d            = acc_q;
    wcnt_d           = wcnt_q;
    result_d         = result_q;
    result_valid_d   = result_valid_q & ~handshake_s;
    overrun_d        = overrun_q;

    if (!en) begin
      // Disabled: discard any partial window; a held result stays put.
      acc_d  = {(WINDOW_LOG2+1){1'b0}};
      wcnt_d = {WINDOW_LOG2{1'b0}};
    end else if (strobe_s) begin
      decision_d       = dec_bit_s;
      decision_valid_d = 1'b1;
      wcnt_d           = wcnt_q + WINDOW_LOG2'(1);
      if (last_s) begin
        acc_d = {(WINDOW_LOG2+1){1'b0}};
        if (!result_valid_q || handshake_s) begin
          result_d       = sum_s;
          result_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        acc_d = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers; sample_q resets high so a strobe held through reset is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q         <= 1'b1;
      decision_q       <= 1'b0;
      decision_valid_q <= 1'b0;
      acc_q            <= {(WINDOW_LOG2+1){1'b0}};
      wcnt_q           <= {WINDOW_LOG2{1'b0}};
      result_q         <= {(WINDOW_LOG2+1){1'b0}};
      result_valid_q   <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      sample_q         <= sample;
      decision_q       <= decision_d;
      decision_valid_q <= decision_valid_d;
      acc_q            <= acc_d;
      wcnt_q           <= wcnt_d;
      result_q         <= result_d;
      result_valid_q   <= result_valid_d;
      overrun_q        <= overrun_d;
    end
  end

  assign decision       = decision_q;
  assign decision_valid = decision_valid_q;
  assign result         = result_q;
  assign result_valid   = result_valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_cmp_decode.sv
// Scoreboard bench for cmp_decode (window 4, two sync stages): directed scenarios then random traffic.
module tb_cmp_decode;

  localparam int WL  = 2;
  localparam int WIN = 4;

  logic clk = 1'b0;
  logic reset, en, cmp_out, cmp_p2, sample, result_ready;
  logic decision, decision_valid, result_valid, overrun;
  logic [WL:0] result;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  cmp_decode #(.WINDOW_LOG2(WL), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .cmp_out        (cmp_out),
    .cmp_p2         (cmp_p2),
    .sample         (sample),
    .decision       (decision),
    .decision_valid (decision_valid),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: comparator samples delayed two clocks, windows as lists of decisions.
  bit m_prev;
  bit m_hist[$];
  int m_win[$];
  bit m_dec_q[$];
  int m_res_q[$];
  bit m_exp_dv;
  bit m_full;
  int m_slot;
  bit m_ovr;
  bit m_synced, m_strobe, m_d;
  int m_sum;

  always @(posedge clk) begin
    if (reset) begin
      m_prev = 1'b1;
      m_hist = '{1'b0, 1'b0};
      m_win.delete();
      m_dec_q.delete();
      m_res_q.delete();
      m_exp_dv = 1'b0;
      m_full = 1'b0;
      m_slot = 0;
      m_ovr = 1'b0;
    end else begin
      m_synced = m_hist.pop_front();
      m_hist.push_back(cmp_out);
      m_strobe = sample && !m_prev && en;
      m_prev = sample;
      if (m_full && result_ready) m_full = 1'b0;
      m_exp_dv = m_strobe;
      if (!en) begin
        m_win.delete();
      end else if (m_strobe) begin
        m_d = m_synced ^ cmp_p2;
        m_dec_q.push_back(m_d);
        m_win.push_back(int'(m_d));
        if (m_win.size() == WIN) begin
          m_sum = 0;
          foreach (m_win[k]) m_sum += m_win[k];
          m_win.delete();
          if (!m_full) begin
            m_full = 1'b1;
            m_slot = m_sum;
            m_res_q.push_back(m_sum);
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("decision_valid", int'(decision_valid), int'(m_exp_dv));
      if (decision_valid) begin
        if (m_dec_q.size() > 0) chk("decision", int'(decision), int'(m_dec_q.pop_front()));
        else chk("decision_unexpected", 1, 0);
      end
      chk("result_valid", int'(result_valid), int'(m_full));
      chk("result", int'(result), m_slot);
      chk("overrun", int'(overrun), int'(m_ovr));
      if (result_valid && result_ready) begin
        if (m_res_q.size() > 0) chk("result_handshake", int'(result), m_res_q.pop_front());
        else chk("result_unexpected", 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_dec(input bit c, input bit p);
    cmp_out = c;
    cmp_p2  = p;
    repeat (3) tick();
    sample = 1'b1;
    tick();
    sample = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cmp_out = 1'b0; cmp_p2 = 1'b0;
    sample = 1'b0; result_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    repeat (2) tick();
    chk("reset_result", int'(result), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    tick();

    // Steady ones, no chopping.
    en = 1'b1; result_ready = 1'b1;
    repeat (4) strobe_dec(1'b1, 1'b0);
    tick();

    // Chop phase alternating: decisions 0,1,0,1.
    strobe_dec(1'b1, 1'b1); strobe_dec(1'b1, 1'b0);
    strobe_dec(1'b1, 1'b1); strobe_dec(1'b1, 1'b0);
    tick();

    // Consumer stalled for two windows.
    result_ready = 1'b0;
    repeat (8) strobe_dec(1'b1, 1'b0);
    chk("stall_overrun", int'(overrun), 1);
    chk("stall_result", int'(result), 4);
    chk("stall_valid", int'(result_valid), 1);
    result_ready = 1'b1;
    tick();
    chk("stall_release_valid", int'(result_valid), 0);

    // Completion coinciding with the accepting handshake.
    do_reset();
    result_ready = 1'b0;
    repeat (4) strobe_dec(1'b1, 1'b0);
    repeat (3) strobe_dec(1'b0, 1'b0);
    cmp_out = 1'b0;
    repeat (3) tick();
    sample = 1'b1; result_ready = 1'b1;
    tick();
    sample = 1'b0; result_ready = 1'b0;
    chk("reload_result", int'(result), 0);
    chk("reload_valid", int'(result_valid), 1);
    chk("reload_overrun", int'(overrun), 0);
    result_ready = 1'b1;
    tick();

    // Enable dropped mid-window.
    repeat (2) strobe_dec(1'b1, 1'b0);
    en = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    repeat (4) strobe_dec(1'b0, 1'b0);
    chk("en_drop_result", int'(result), 0);

    // Reset mid-window with sample held high.
    repeat (2) strobe_dec(1'b1, 1'b0);
    sample = 1'b1; reset = 1'b1;
    repeat (2) tick();
    chk("midreset_valid", int'(result_valid), 0);
    chk("midreset_dv", int'(decision_valid), 0);
    reset = 1'b0;
    repeat (3) tick();
    sample = 1'b0; tick();
    sample = 1'b1; tick();
    sample = 1'b0; tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cmp_out      = 1'($urandom);
      cmp_p2       = 1'($urandom);
      sample       = 1'($urandom);
      en           = ($urandom_range(0, 19) != 0);
      result_ready = (i % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; sample = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_decode.md
# cmp_decode

Receive side of the comparator clocking scheme. Takes the asynchronous output of the chopped analog comparator together with the `cmp_p2` phase and `sample` strobe from the comparator phase generator. Synchronizes and chopper-demodulates each decision. Accumulates the decisions over a power-of-two window and hands the ones-count to downstream logic on a valid/ready interface.

## Interface
Parameters:
- `WINDOW_LOG2`, 8: window length = 2^WINDOW_LOG2 decisions.
- `SYNC_STAGES`, 2: flops in the `cmp_out` synchronizer; legal range 2..4.

Ports:
- `clk`  in  1  single clock; same clock as the phase generator.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  decoding enable.
- `cmp_out`  in  1  raw comparator output, asynchronous.
- `cmp_p2`  in  1  chop phase from the generator; 1 = comparator inputs swapped.
- `sample`  in  1  decision strobe from the generator, synchronous to `clk`.
- `decision`  out  1  demodulated decision.
- `decision_valid`  out  1  one-cycle pulse per decision.
- `result`  out  WINDOW_LOG2+1  ones-count of the last completed window.
- `result_valid`  out  1  `result` holds an unconsumed value.
- `result_ready`  in  1  consumer accepts `result`.
- `overrun`  out  1  sticky; a window completed while the previous one was unconsumed.

## Operation
- `cmp_out` passes through a SYNC_STAGES flop chain to produce `cmp_sync`.
- `sample_q` registers `sample`. Strobe = `sample & ~sample_q`, i.e. a rising edge of `sample`.
- On a strobe with `en`=1: `decision <= cmp_sync ^ cmp_p2`, and `decision_valid` pulses.
- Strobes with `en`=0 are ignored.
- Accumulator `acc` (WINDOW_LOG2+1 bits) and window counter `wcnt` (WINDOW_LOG2 bits) advance on every accepted decision.
  - `acc` adds the decision.
  - `wcnt` increments and wraps to 0.
- Window completes on the decision where `wcnt` = 2^WINDOW_LOG2−1. On completion:
  - The final sum is acc+decision, range 0..2^WINDOW_LOG2; no saturation is needed.
  - If the output slot is free, or is being consumed this cycle (`result_valid & result_ready`), load `result` with the final sum and set `result_valid`.
  - Otherwise keep the old `result`, drop the new sum, and set `overrun`.
  - In every case `acc` restarts at 0.
- Handshake:
  - `result_valid` falls on the cycle after `result_valid & result_ready`, unless a completion reloads it that same cycle.
  - `result` is stable while `result_valid`=1.
- `en` 1→0 clears `acc` and `wcnt`, which discards the partial window. A held `result`/`result_valid` is unaffected.
- A new window starts at the first accepted strobe after `en` returns to 1.
- `overrun` is cleared only by `reset`.

## Timing
- Reset values:
  - `decision`, `decision_valid`, `result`, `result_valid`, `overrun`, `acc`, `wcnt` and the synchronizer flops are all 0.
  - `sample_q` resets to 1, so a `sample` held high through reset produces no strobe.
- Strobe at cycle t (sample seen high at posedge t, low at t−1) → `decision`/`decision_valid` at t+1. `cmp_sync` used at t reflects `cmp_out` from cycle t−SYNC_STAGES.
- `result_valid` rises at t+1 for the completing strobe at t.
- Reset mid-window or mid-handshake: all state returns to reset values at the next edge; no partial result is emitted.
- A strobe is at most one per 2 cycles by construction of `sample`. Back-to-back strobe cycles are not a legal input.

## Structure
- Shared package `cmp_pkg`:
  - `CMP_WINDOW_LOG2_DEFAULT` = 8.
  - `CMP_SYNC_STAGES_DEFAULT` = 2.
  - Typedef `cmp_result_t` sized WINDOW_LOG2+1, used by downstream consumers.
- Sub-module `cmp_sync`: a parameterized flop-chain synchronizer with reset to 0, reusable for other async analog outputs.
- The rest is flat: edge detect, demodulator, accumulator, output slot.

## Test plan
All scenarios use WINDOW_LOG2=2 (window 4) and SYNC_STAGES=2.
- `cmp_out`=1 steady, `cmp_p2`=0, `en`=1, `result_ready`=1, 4 strobes → 4 `decision_valid` pulses with `decision`=1; `result`=4 with a one-cycle `result_valid`; `overrun`=0.
- `cmp_out`=1 steady, `cmp_p2` toggling each strobe (1,0,1,0) → decisions 0,1,0,1; `result`=2.
- `result_ready`=0, 8 strobes with `cmp_out`=1 → `result`=4 held, `result_valid`=1, `overrun`=1 after the 8th decision. Raising `result_ready` then drops `result_valid` next cycle.
- Completion on the same cycle as the accepting handshake (`result_ready`=1, second window all 0s) → `result` reloads to 0, `result_valid` stays 1, `overrun`=0.
- Drop `en` after 2 decisions, re-raise, give 4 strobes with `cmp_out`=0 → `result`=0. The partial window is never reported.
- Assert `reset` mid-window with `sample` high → all outputs 0. No strobe until `sample` goes low then high again.
